// File: rtl/dmem_responder.sv
// dmem_responder: data-memory side of the single-cycle RV32I load/store path.
// Stores commit on the rising CLOCK edge. Loads are combinational and
// sign- or zero-extended. The block also holds the MemtoReg writeback mux and
// the fault tracking (misalignment count, sticky access_err).
// Optional build macro: DMEM_MMIO_EN adds the GPIO, cycle-counter and status
// registers at MMIO_BASE.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        CLOCK,
    input  logic        RST_n,
    input  logic        ena_wr,
    input  logic        ena_rd,
    input  logic        MemtoReg,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] datareg_wr,
    output logic [7:0]  gpio_out,
    output logic [15:0] misalign_cnt,
    output logic        access_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic          acc;
    logic          in_ram;
    logic          mis_size;
    logic          st_f3_ok;
    logic          ld_f3_ok;
    logic          mmio_gpio;
    logic          mmio_cyc;
    logic          mmio_stat;
    logic          mmio_hit;
    logic          mmio_word;
    logic          misaligned;
    logic          out_of_range;
    logic          err_set;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   mmio_rdata;
    logic [31:0]   load_data;

    logic [15:0]   misalign_cnt_q, misalign_cnt_d;
    logic          access_err_q,   access_err_d;

`ifdef DMEM_MMIO_EN
    logic [7:0]    gpio_q, gpio_d;
    logic [31:0]   cyc_q,  cyc_d;

    // Peripheral register decode; only the three exact word addresses exist.
    always_comb begin
        mmio_gpio = (addr == MMIO_BASE);
        mmio_cyc  = (addr == (MMIO_BASE + 32'd4));
        mmio_stat = (addr == (MMIO_BASE + 32'd8));
        mmio_hit  = mmio_gpio | mmio_cyc | mmio_stat;
        mmio_word = (funct3 == 3'b010);
        mmio_rdata = 32'h0;
        if (mmio_gpio) mmio_rdata = {24'h0, gpio_q};
        if (mmio_cyc)  mmio_rdata = cyc_q;
        if (mmio_stat) mmio_rdata = {15'h0, access_err_q, misalign_cnt_q};
    end

    // Next-state of GPIO and the free-running cycle counter.
    always_comb begin
        gpio_d = gpio_q;
        cyc_d  = cyc_q + 32'd1;
        if (ena_wr && mmio_gpio && mmio_word) gpio_d = wdata[7:0];
    end

    // Peripheral state registers.
    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            gpio_q <= 8'h0;
            cyc_q  <= 32'h0;
        end else begin
            gpio_q <= gpio_d;
            cyc_q  <= cyc_d;
        end
    end

    assign gpio_out = gpio_q;
`else
    logic unused_mmio_base;

    // Without the peripheral window every non-RAM address is out of range.
    always_comb begin
        mmio_gpio  = 1'b0;
        mmio_cyc   = 1'b0;
        mmio_stat  = 1'b0;
        mmio_hit   = 1'b0;
        mmio_word  = 1'b0;
        mmio_rdata = 32'h0;
    end

    assign unused_mmio_base = ^MMIO_BASE;
    assign gpio_out         = 8'h0;
`endif

    // Address, size and fault decode for the current access.
    always_comb begin
        word_idx     = addr[AW+1:2];
        acc          = ena_wr | ena_rd;
        in_ram       = ({1'b0, addr} < RAM_BYTES);
        mis_size     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        st_f3_ok     = funct3 inside {3'b000, 3'b001, 3'b010};
        ld_f3_ok     = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned   = acc && (mmio_hit ? !mmio_word : mis_size);
        out_of_range = acc && !in_ram && !mmio_hit;
        err_set      = out_of_range
                     || (ena_wr && !st_f3_ok)
                     || (!ena_wr && ena_rd && !ld_f3_ok)
                     || (ena_wr && (mmio_cyc || mmio_stat))
                     || (ena_wr && ena_rd);
    end

    // Store lane selection; a reset cycle never writes the array.
    always_comb begin
        ram_we    = RST_n && ena_wr && st_f3_ok && !misaligned && in_ram;
        ram_be    = 4'b0000;
        ram_wdata = wdata;
        case (funct3)
            3'b000: begin
                ram_be    = 4'(4'b0001 << addr[1:0]);
                ram_wdata = {4{wdata[7:0]}};
            end
            3'b001: begin
                ram_be    = addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{wdata[15:0]}};
            end
            3'b010:  ram_be = 4'b1111;
            default: ram_be = 4'b0000;
        endcase
    end

    // Byte-enabled RAM write at the edge.
    always_ff @(posedge CLOCK) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem_q[word_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    // Combinational load path with size/sign extension.
    always_comb begin
        rd_word   = mem_q[word_idx];
        rd_half   = addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (addr[1:0])
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        load_data = 32'h0;
        if (ena_rd && ld_f3_ok && !misaligned) begin
            if (in_ram) begin
                case (funct3)
                    3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
                    3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
                    3'b010:  load_data = rd_word;
                    3'b100:  load_data = {24'h0, rd_byte};
                    3'b101:  load_data = {16'h0, rd_half};
                    default: load_data = 32'h0;
                endcase
            end else if (mmio_hit) begin
                load_data = mmio_rdata;
            end
        end
    end

    // Fault counters: saturating misalignment count and sticky error.
    always_comb begin
        misalign_cnt_d = misalign_cnt_q;
        access_err_d   = access_err_q | err_set;
        if (misaligned && (misalign_cnt_q != 16'hFFFF)) begin
            misalign_cnt_d = misalign_cnt_q + 16'd1;
        end
    end

    // Fault state registers.
    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            misalign_cnt_q <= 16'h0;
            access_err_q   <= 1'b0;
        end else begin
            misalign_cnt_q <= misalign_cnt_d;
            access_err_q   <= access_err_d;
        end
    end

    assign misalign_cnt = misalign_cnt_q;
    assign access_err   = access_err_q;
    assign datareg_wr   = MemtoReg ? load_data : addr;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder; expected load data goes through a
// scoreboard queue, registered fault state is compared directly.
module tb_dmem_responder;

    logic        CLOCK = 1'b0;
    logic        RST_n;
    logic        ena_wr, ena_rd, MemtoReg;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] datareg_wr;
    logic [7:0]  gpio_out;
    logic [15:0] misalign_cnt;
    logic        access_err;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc_model = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

    dmem_responder dut (
        .CLOCK(CLOCK), .RST_n(RST_n), .ena_wr(ena_wr), .ena_rd(ena_rd),
        .MemtoReg(MemtoReg), .funct3(funct3), .addr(addr), .wdata(wdata),
        .datareg_wr(datareg_wr), .gpio_out(gpio_out),
        .misalign_cnt(misalign_cnt), .access_err(access_err)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK);
        if (!RST_n) cyc_model = 0;
        else        cyc_model = cyc_model + 1;
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        ena_wr = wr; ena_rd = rd; funct3 = f3; addr = a; wdata = d;
        MemtoReg = 1'b1;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        idle();
        RST_n = 1'b0;
        tick();
        RST_n = 1'b1;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        idle();
        tick(); tick();
        RST_n = 1'b1;
        n_checks++;
        if (gpio_out !== 8'h0 || misalign_cnt !== 16'h0 || access_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gpio=%h cnt=%h err=%b, expected 00 0000 0",
                     gpio_out, misalign_cnt, access_err);
        end
    endtask

    task automatic test_word();
        logic [31:0] v;
        drive(1'b1, 1'b0, F_W, 32'h10, 32'hDEADBEEF);
        n_checks++;
        if (datareg_wr !== 32'h0) begin
            n_fail++;
            $display("FAIL no_read_zero: got %h expected 00000000", datareg_wr);
        end
        tick();
        sb_q.push_back('{"lw_10", 32'hDEADBEEF});
        drive(1'b0, 1'b1, F_W, 32'h10, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            sb_q.push_back('{$sformatf("rand_w%0d", i), v});
            drive(1'b1, 1'b0, F_W, 32'h20 + 32'(4 * i), v);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, F_W, 32'h20 + 32'(4 * i), 32'h0);
            e = sb_q.pop_front(); n_checks++;
            if (datareg_wr !== e.val) begin
                n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
            end
            tick();
        end
    endtask

    task automatic test_subword();
        logic [2:0]  f3s [7] = '{F_B, F_BU, F_W, F_W, F_H, F_HU, F_H};
        logic [31:0] as  [7] = '{32'h11, 32'h11, 32'h10, 32'h14, 32'h16, 32'h16, 32'h14};
        logic [31:0] exs [7] = '{32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF, 32'hABCD3344,
                                 32'hFFFFABCD, 32'h0000ABCD, 32'h00003344};
        drive(1'b1, 1'b0, F_B, 32'h11, 32'hFFFFFF80); tick();
        drive(1'b1, 1'b0, F_W, 32'h14, 32'h11223344); tick();
        drive(1'b1, 1'b0, F_H, 32'h16, 32'h5555ABCD); tick();
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back('{$sformatf("subword_%0d", i), exs[i]});
            drive(1'b0, 1'b1, f3s[i], as[i], 32'h0);
            e = sb_q.pop_front(); n_checks++;
            if (datareg_wr !== e.val) begin
                n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
            end
            tick();
        end
        n_checks++;
        if (access_err !== 1'b0 || misalign_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL clean_access: got err=%b cnt=%h expected 0 0000", access_err, misalign_cnt);
        end
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, F_W, 32'h12, 32'h55555555); tick();
        n_checks++;
        if (misalign_cnt !== 16'h1) begin
            n_fail++; $display("FAIL misalign_sw: got %h expected 0001", misalign_cnt);
        end
        sb_q.push_back('{"lw_after_missw", 32'hDEAD80EF});
        drive(1'b0, 1'b1, F_W, 32'h10, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        sb_q.push_back('{"lh_13", 32'h0});
        drive(1'b0, 1'b1, F_H, 32'h13, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        n_checks++;
        if (misalign_cnt !== 16'h2 || access_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_lh: got cnt=%h err=%b expected 0002 0", misalign_cnt, access_err);
        end
        for (int i = 0; i < 65540; i++) begin
            drive(1'b0, 1'b1, F_H, 32'h13, 32'h0);
            tick();
        end
        n_checks++;
        if (misalign_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL misalign_sat: got %h expected ffff", misalign_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, F_W, 32'h1000, 32'h0); tick();
        n_checks++;
        if (access_err !== 1'b1) begin
            n_fail++; $display("FAIL err_before_reset: got %b expected 1", access_err);
        end
        drive(1'b1, 1'b0, F_W, 32'h10, 32'h12345678);
        RST_n = 1'b0;
        tick();
        RST_n = 1'b1;
        n_checks++;
        if (gpio_out !== 8'h0 || misalign_cnt !== 16'h0 || access_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got gpio=%h cnt=%h err=%b expected 00 0000 0",
                     gpio_out, misalign_cnt, access_err);
        end
        sb_q.push_back('{"ram_kept", 32'hDEAD80EF});
        drive(1'b0, 1'b1, F_W, 32'h10, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [31:0] old;
        drive(1'b0, 1'b1, F_W, 32'h20, 32'h0);
        old = datareg_wr;
        tick();
        drive(1'b1, 1'b0, F_W, 32'h40, 32'h600DF00D); tick();
        sb_q.push_back('{"conflict_preread", 32'h600DF00D});
        drive(1'b1, 1'b1, F_W, 32'h40, 32'hCAFEF00D);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        n_checks++;
        if (access_err !== 1'b1) begin
            n_fail++; $display("FAIL conflict_err: got %b expected 1", access_err);
        end
        sb_q.push_back('{"conflict_stored", 32'hCAFEF00D});
        drive(1'b0, 1'b1, F_W, 32'h40, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        if (old === 32'hx) $display("note: word 0x20 unexpectedly unknown");
    endtask

    task automatic test_bad_funct3();
        pulse_reset();
        drive(1'b1, 1'b0, F_BAD, 32'h10, 32'h99999999); tick();
        n_checks++;
        if (access_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_f3_store_err: got %b expected 1", access_err);
        end
        sb_q.push_back('{"bad_f3_load", 32'h0});
        drive(1'b0, 1'b1, F_BAD, 32'h10, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        sb_q.push_back('{"bad_f3_nowrite", 32'hDEAD80EF});
        drive(1'b0, 1'b1, F_W, 32'h10, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
    endtask

    task automatic test_range();
        pulse_reset();
        drive(1'b1, 1'b0, F_W, 32'hFFC, 32'h0BADC0DE); tick();
        drive(1'b1, 1'b0, F_W, 32'h0, 32'h11111111); tick();
        sb_q.push_back('{"lw_last_word", 32'h0BADC0DE});
        drive(1'b0, 1'b1, F_W, 32'hFFC, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        n_checks++;
        if (access_err !== 1'b0) begin
            n_fail++; $display("FAIL in_range_err: got %b expected 0", access_err);
        end
        sb_q.push_back('{"lw_1000", 32'h0});
        drive(1'b0, 1'b1, F_W, 32'h1000, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        drive(1'b1, 1'b0, F_W, 32'h1000, 32'h22222222); tick();
        idle(); tick(); tick(); tick();
        n_checks++;
        if (access_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_err_sticky: got %b expected 1", access_err);
        end
        sb_q.push_back('{"no_alias_write", 32'h11111111});
        drive(1'b0, 1'b1, F_W, 32'h0, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        drive(1'b0, 1'b1, F_W, 32'h1234, 32'h0);
        MemtoReg = 1'b0;
        #1;
        n_checks++;
        if (datareg_wr !== 32'h1234) begin
            n_fail++; $display("FAIL passthrough: got %h expected 00001234", datareg_wr);
        end
        tick();
    endtask

    task automatic test_mmio();
        pulse_reset();
`ifdef DMEM_MMIO_EN
        drive(1'b1, 1'b0, F_W, 32'hFFFF0000, 32'h123456A5); tick();
        n_checks++;
        if (gpio_out !== 8'hA5) begin
            n_fail++; $display("FAIL gpio_write: got %h expected a5", gpio_out);
        end
        sb_q.push_back('{"gpio_read", 32'h000000A5});
        drive(1'b0, 1'b1, F_W, 32'hFFFF0000, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{$sformatf("cycle_rd%0d", i), 32'(cyc_model)});
            drive(1'b0, 1'b1, F_W, 32'hFFFF0004, 32'h0);
            e = sb_q.pop_front(); n_checks++;
            if (datareg_wr !== e.val) begin
                n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
            end
            tick();
        end
        n_checks++;
        if (access_err !== 1'b0) begin
            n_fail++; $display("FAIL mmio_err_clean: got %b expected 0", access_err);
        end
        drive(1'b1, 1'b0, F_W, 32'hFFFF0004, 32'h0); tick();
        n_checks++;
        if (access_err !== 1'b1) begin
            n_fail++; $display("FAIL ro_store_err: got %b expected 1", access_err);
        end
        sb_q.push_back('{"cycle_after_ro", 32'(cyc_model)});
        drive(1'b0, 1'b1, F_W, 32'hFFFF0004, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        sb_q.push_back('{"mmio_half", 32'h0});
        drive(1'b0, 1'b1, F_H, 32'hFFFF0000, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
        sb_q.push_back('{"status_read", 32'h00010001});
        drive(1'b0, 1'b1, F_W, 32'hFFFF0008, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
`else
        drive(1'b1, 1'b0, F_W, 32'hFFFF0000, 32'h000000A5); tick();
        n_checks++;
        if (gpio_out !== 8'h0 || access_err !== 1'b1) begin
            n_fail++;
            $display("FAIL window_oor: got gpio=%h err=%b expected 00 1", gpio_out, access_err);
        end
        sb_q.push_back('{"window_read", 32'h0});
        drive(1'b0, 1'b1, F_W, 32'hFFFF0004, 32'h0);
        e = sb_q.pop_front(); n_checks++;
        if (datareg_wr !== e.val) begin
            n_fail++; $display("FAIL %s: got %h expected %h", e.name, datareg_wr, e.val);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_reset_mid();
        test_conflict();
        test_bad_funct3();
        test_range();
        test_mmio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the single-cycle RV32I core. It is the memory side of the core's load/store interface: it receives the core's ALU address, store data and read/write enables, and performs stores on the clock edge. It returns sign/zero-extended load data in the same cycle. It also contains the MemtoReg writeback mux that produces the core's register write data, and tracks access faults (misaligned, out-of-range, conflicting enables).

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words; RAM region is byte addresses 0 to DEPTH_WORDS*4-1
MMIO_BASE, 32'hFFFF_0000, base byte address of the peripheral window (used only with DMEM_MMIO_EN)

Ports:
CLOCK  input  1  core clock, all state updates on rising edge
RST_n  input  1  synchronous active-low reset
ena_wr  input  1  store enable from core
ena_rd  input  1  load enable from core
MemtoReg  input  1  writeback select: 1 = load data, 0 = address passthrough
funct3  input  3  instr[14:12], access size and sign
addr  input  32  byte address (core ALU result)
wdata  input  32  store data (core rs2 value)
datareg_wr  output  32  register-file write data back to core
gpio_out  output  8  GPIO register, used only with DMEM_MMIO_EN
misalign_cnt  output  16  saturating count of misaligned accesses
access_err  output  1  sticky fault flag

Behaviour:
- Reset (RST_n=0 at edge): gpio_out=0, misalign_cnt=0, access_err=0, cycle counter=0. RAM contents are not cleared. A store presented in a reset cycle is dropped.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. An address is in the RAM region if addr < DEPTH_WORDS*4.
- Stores commit on the rising edge when ena_wr=1, the access is aligned, and the address is in range.
  - SB (000): byte lane addr[1:0] gets wdata[7:0].
  - SH (001): half addr[1] gets wdata[15:0].
  - SW (010): full word.
  - Any other funct3 with ena_wr: no write, access_err set.
- Loads are combinational from the current array contents (zero added latency) when ena_rd=1:
  - LB 000: sign-extended byte.
  - LH 001: sign-extended half.
  - LW 010: full word.
  - LBU 100: zero-extended byte.
  - LHU 101: zero-extended half.
  - Other funct3 returns 0 and sets access_err.
- load_data=0 whenever ena_rd=0.
- Misaligned access (H with addr[0]=1, W with addr[1:0]!=0, for either load or store):
  - Write suppressed and load returns 0.
  - misalign_cnt increments on the edge, saturating at 16'hFFFF.
- Out-of-range access (neither RAM nor an enabled MMIO register): write dropped, load returns 0, access_err set on the edge.
- ena_wr=1 and ena_rd=1 together:
  - Treated as a store.
  - Same-cycle load data shows the pre-write contents.
  - access_err set.
- access_err is sticky; only reset clears it.
- datareg_wr = MemtoReg ? load_data : addr (purely combinational).
- A write to an address and a load of the same address in the next cycle returns the new value (no forwarding needed, since the array is updated at the edge).

Optional Feature:
Macro DMEM_MMIO_EN. When defined, three word-only (SW/LW; other sizes count as misaligned) registers exist in the window:
- MMIO_BASE+0x0 GPIO: RW, bits[7:0] drive gpio_out, upper read bits are 0.
- MMIO_BASE+0x4 cycle counter: RO, 32-bit, +1 every non-reset cycle, wraps at 2^32.
- MMIO_BASE+0x8 status: RO, {15'b0, access_err, misalign_cnt}.
- A store to an RO register is ignored and sets access_err.
- Any other offset in the window is out of range.

When the macro is not defined: the whole window is out of range, gpio_out is tied to 0, and no counter logic is built.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, next cycle LW 0x10 with MemtoReg=1 -> datareg_wr=0xDEADBEEF.
- SB addr 0x11 wdata 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- SW addr 0x12 -> memory unchanged, misalign_cnt=1. LH addr 0x13 -> datareg_wr=0, misalign_cnt=2. 65540 misaligned accesses -> misalign_cnt holds 0xFFFF.
- DEPTH_WORDS=1024: LW addr 0x1000 -> datareg_wr=0, access_err=1 and remains 1. MemtoReg=0 with addr 0x1234 -> datareg_wr=0x1234.
- With DMEM_MMIO_EN: SW 0x000000A5 to 0xFFFF0000 -> gpio_out=0xA5. LW 0xFFFF0004 on two consecutive cycles -> values differ by 1. SW to 0xFFFF0004 -> access_err=1, counter unaffected.
- Pulse RST_n=0 for one cycle mid-sequence with ena_wr=1 -> store dropped, gpio_out=0, misalign_cnt=0, access_err=0. Prior RAM data is still readable.
